// File: rtl/wb_master_arbiter_if.sv
// Bundle of the upstream master buses and the shared downstream Wishbone port.
// Latency: none, wires only.
// Backpressure: none here; the arbiter stalls non-owners by withholding ack/err/rty.
interface wb_master_arbiter_if #(
  parameter int NUM_MASTERS   = 2,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) ();
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  // upstream master side, master k occupies slice k of each packed vector
  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_adr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_i;
  logic [NUM_MASTERS*SEL_WIDTH-1:0]     m_sel_i;
  logic [NUM_MASTERS-1:0]               m_we_i;
  logic [NUM_MASTERS-1:0]               m_cyc_i;
  logic [NUM_MASTERS-1:0]               m_stb_i;
  logic [NUM_MASTERS*3-1:0]             m_cti_i;
  logic [NUM_MASTERS*2-1:0]             m_bte_i;
  logic [DATA_WIDTH-1:0]                m_dat_o;
  logic [NUM_MASTERS-1:0]               m_ack_o;
  logic [NUM_MASTERS-1:0]               m_err_o;
  logic [NUM_MASTERS-1:0]               m_rty_o;

  // shared downstream port
  logic [ADDRESS_WIDTH-1:0] s_adr_o;
  logic [DATA_WIDTH-1:0]    s_dat_o;
  logic [SEL_WIDTH-1:0]     s_sel_o;
  logic                     s_we_o;
  logic                     s_cyc_o;
  logic                     s_stb_o;
  logic [2:0]               s_cti_o;
  logic [1:0]               s_bte_o;
  logic [DATA_WIDTH-1:0]    s_dat_i;
  logic                     s_ack_i;
  logic                     s_err_i;
  logic                     s_rty_i;

  // arbiter view: masters request in, shared bus master out
  modport master (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

  // environment view: upstream masters and the downstream slave
  modport slave (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i
  );
endinterface

// File: rtl/wb_master_arbiter.sv
// N-to-1 round-robin Wishbone B3 master arbiter; grant held for the whole CYC cycle.
// Latency: 1 cycle from m_cyc_i to s_cyc_o, then combinational pass-through.
// Backpressure: non-owners get no response until granted. Optional macro WB_ARB_TIMEOUT_EN adds a hung-slave watchdog.
// The interface instance must be built with the same NUM_MASTERS/ADDRESS_WIDTH/DATA_WIDTH.
module wb_master_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  wb_master_arbiter_if.master    bus,
  output logic [NUM_MASTERS-1:0] grant_o
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);

  if (NUM_MASTERS < 1 || NUM_MASTERS > 8) begin : g_chk_num
    $error("wb_master_arbiter: NUM_MASTERS must be 1..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_chk_tmo
    $error("wb_master_arbiter: TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ABORT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] pick;
  logic             any_req;
  logic             own_cyc, own_stb, slv_resp, timeout_hit;

  // per-master views of the packed request buses
  logic [ADDRESS_WIDTH-1:0] adr_arr [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]    dat_arr [NUM_MASTERS];
  logic [SEL_WIDTH-1:0]     sel_arr [NUM_MASTERS];
  logic [2:0]               cti_arr [NUM_MASTERS];
  logic [1:0]               bte_arr [NUM_MASTERS];

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
    assign adr_arr[k] = bus.m_adr_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign dat_arr[k] = bus.m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
    assign sel_arr[k] = bus.m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
    assign cti_arr[k] = bus.m_cti_i[k*3 +: 3];
    assign bte_arr[k] = bus.m_bte_i[k*2 +: 2];
  end

  assign own_cyc  = bus.m_cyc_i[owner_q];
  assign own_stb  = bus.m_stb_i[owner_q];
  assign slv_resp = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;

  // read data is broadcast; only the owner's ack makes it meaningful
  assign bus.m_dat_o = bus.s_dat_i;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
    return IDX_W'((int'(base) + off) % NUM_MASTERS);
  endfunction

  // round-robin scan from last+1; descending loop so the nearest requester is written last
  always_comb begin
    pick    = last_q;
    any_req = 1'b0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      if (bus.m_cyc_i[rr_idx(last_q, i)]) begin
        pick    = rr_idx(last_q, i);
        any_req = 1'b1;
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  // count strobed cycles without a slave response; any response or leaving BUSY clears it
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != ST_BUSY || slv_resp) begin
      tmo_cnt_q <= '0;
    end else if (own_cyc && own_stb) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  // fires on the stalled cycle that brings the count up to TIMEOUT_CYCLES
  assign timeout_hit = (state_q == ST_BUSY) && own_cyc && own_stb && !slv_resp &&
                       (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // state, owner and round-robin pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // next state: grant in IDLE, release when the owner drops cyc
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_BUSY;
          owner_d = pick;
        end
      end
      ST_BUSY: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end else if (timeout_hit) begin
          state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs: mux the owner onto the shared bus and route responses back to it only
  always_comb begin
    grant_o     = '0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.s_we_o  = 1'b0;
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_cti_o = '0;
    bus.s_bte_o = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_rty_o = '0;
    case (state_q)
      ST_BUSY: begin
        grant_o[owner_q] = 1'b1;
        bus.s_adr_o      = adr_arr[owner_q];
        bus.s_dat_o      = dat_arr[owner_q];
        bus.s_sel_o      = sel_arr[owner_q];
        bus.s_we_o       = bus.m_we_i[owner_q];
        bus.s_cti_o      = cti_arr[owner_q];
        bus.s_bte_o      = bte_arr[owner_q];
        if (timeout_hit) begin
          bus.m_err_o[owner_q] = 1'b1;
        end else begin
          bus.s_cyc_o          = own_cyc;
          bus.s_stb_o          = own_stb;
          bus.m_ack_o[owner_q] = bus.s_ack_i;
          bus.m_err_o[owner_q] = bus.s_err_i;
          bus.m_rty_o[owner_q] = bus.s_rty_i;
        end
      end
      ST_ABORT: grant_o[owner_q] = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter with a transaction-level reference model.
// Latency: checks the 1-cycle arbitration delay and combinational pass-through.
// Backpressure: a registered slave answers one cycle after each strobe, or never.
`timescale 1ns/1ps
module tb_wb_master_arbiter;
  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NM-1:0] grant;

  wb_master_arbiter_if #(.NUM_MASTERS(NM), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb_master_arbiter #(
    .NUM_MASTERS(NM), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .grant_o(grant)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  bit chk_en  = 1'b0;
  int smode   = 0;              // slave: 0 silent, 1 ack, 2 err, 3 rty
  logic [DW-1:0] slave_rdata = 32'hDEADBEEF;

  // captured per-master results of the last xfer
  logic [NM-1:0] r_ack [NM];
  logic [NM-1:0] r_err [NM];
  logic [NM-1:0] r_rty [NM];
  logic [DW-1:0] r_dat [NM];
  logic          r_c0 [NM];
  logic          r_c1 [NM];
  logic          r_cresp [NM];
  int            r_lat [NM];
  int            r_nack [NM];

  int gseq[$];
  int gaps[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  function automatic bit bitof(input logic [NM-1:0] v, input int i);
    logic [NM-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // ---------------- reference model ----------------
  int mo_owner = -1;     // -1 while nobody owns the bus
  int mo_last  = NM - 1;
  int mo_stall = 0;
  bit mo_abort = 1'b0;

  function automatic bit any_resp();
    return bus.s_ack_i || bus.s_err_i || bus.s_rty_i;
  endfunction

  function automatic int rr_pick();
    for (int i = 1; i <= NM; i++) begin
      if (bitof(bus.m_cyc_i, (mo_last + i) % NM)) return (mo_last + i) % NM;
    end
    return -1;
  endfunction

  function automatic bit mo_hit();
    if (!TO_EN || mo_owner < 0 || mo_abort) return 1'b0;
    return bitof(bus.m_cyc_i, mo_owner) && bitof(bus.m_stb_i, mo_owner) &&
           !any_resp() && (mo_stall == TO - 1);
  endfunction

  function automatic logic [127:0] exp_sbus();
    int o;
    logic cy, st;
    o = mo_owner;
    if (o < 0 || mo_abort) return '0;
    cy = bitof(bus.m_cyc_i, o);
    st = bitof(bus.m_stb_i, o);
    if (mo_hit()) begin cy = 1'b0; st = 1'b0; end
    return {51'd0, AW'(bus.m_adr_i >> (o*AW)), DW'(bus.m_dat_i >> (o*DW)),
            SW'(bus.m_sel_i >> (o*SW)), bitof(bus.m_we_i, o), cy, st,
            3'(bus.m_cti_i >> (o*3)), 2'(bus.m_bte_i >> (o*2))};
  endfunction

  function automatic logic [127:0] exp_resp();
    logic [NM-1:0] a, e, r, one;
    a = '0; e = '0; r = '0;
    if (mo_owner >= 0 && !mo_abort) begin
      one = NM'(1) << mo_owner;
      if (mo_hit()) e = one;
      else begin
        a = bus.s_ack_i ? one : '0;
        e = bus.s_err_i ? one : '0;
        r = bus.s_rty_i ? one : '0;
      end
    end
    return {122'd0, a, e, r};
  endfunction

  // model update on each active edge
  initial forever begin
    @(posedge clk);
    cyc_cnt++;
    if (rst) begin
      mo_owner = -1; mo_last = NM - 1; mo_stall = 0; mo_abort = 1'b0;
    end else if (mo_owner < 0) begin
      mo_owner = rr_pick();
      mo_stall = 0;
    end else if (!bitof(bus.m_cyc_i, mo_owner)) begin
      mo_last = mo_owner; mo_owner = -1; mo_abort = 1'b0; mo_stall = 0;
    end else if (!mo_abort) begin
      if (mo_hit()) begin mo_abort = 1'b1; mo_stall = 0; end
      else if (any_resp()) mo_stall = 0;
      else if (bitof(bus.m_stb_i, mo_owner)) mo_stall++;
    end
  end

  // the one per-cycle compare process
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("grant", grant, (mo_owner < 0) ? 128'd0 : (128'd1 << mo_owner));
      chk("sbus", {51'd0, bus.s_adr_o, bus.s_dat_o, bus.s_sel_o, bus.s_we_o, bus.s_cyc_o,
                   bus.s_stb_o, bus.s_cti_o, bus.s_bte_o}, exp_sbus());
      chk("resp", {122'd0, bus.m_ack_o, bus.m_err_o, bus.m_rty_o}, exp_resp());
      chk("rdata", bus.m_dat_o, bus.s_dat_i);
    end
  end

  // grant-order monitor: owner sequence and idle gaps between owners
  initial begin
    logic [NM-1:0] prev_g;
    int zero_run;
    prev_g = '0; zero_run = 0;
    forever begin
      @(negedge clk);
      if (grant == '0) zero_run++;
      else begin
        if (prev_g == '0) begin
          if (gseq.size() > 0) gaps.push_back(zero_run);
          gseq.push_back(int'(grant[1]));
        end
        zero_run = 0;
      end
      prev_g = grant;
    end
  end

  // registered slave: answers one cycle after seeing an unanswered strobe
  initial begin
    bit req;
    bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0; bus.s_dat_i = '0;
    forever begin
      @(negedge clk);
      req = bus.s_cyc_o && bus.s_stb_o && !(bus.s_ack_i || bus.s_err_i || bus.s_rty_i);
      @(posedge clk); #1;
      bus.s_ack_i = req && (smode == 1);
      bus.s_err_i = req && (smode == 2);
      bus.s_rty_i = req && (smode == 3);
      bus.s_dat_i = slave_rdata;
    end
  end

  // one master cycle of nbeat transfers; single (cti 000) or incrementing burst (010..111)
  task automatic xfer(input int k, input int nbeat, input bit we, input logic [AW-1:0] adr,
                      input logic [DW-1:0] wdat);
    int  lat;
    bit  done;
    lat = 0;
    r_nack[k] = 0;
    bus.m_cyc_i[k] = 1'b1;
    bus.m_stb_i[k] = 1'b1;
    bus.m_we_i[k]  = we;
    bus.m_sel_i[k*SW +: SW] = 4'hF;
    bus.m_bte_i[k*2 +: 2]   = 2'b00;
    for (int b = 0; b < nbeat; b++) begin
      bus.m_adr_i[k*AW +: AW] = adr + AW'(4 * b);
      bus.m_dat_i[k*DW +: DW] = wdat + DW'(b);
      bus.m_cti_i[k*3 +: 3]   = (nbeat == 1) ? 3'b000 : ((b == nbeat - 1) ? 3'b111 : 3'b010);
      done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
        @(negedge clk);
        lat++;
        if (lat == 1) r_c0[k] = bus.s_cyc_o;
        if (lat == 2) r_c1[k] = bus.s_cyc_o;
        if (bitof(bus.m_ack_o | bus.m_err_o | bus.m_rty_o, k)) begin
          done = 1'b1;
          r_ack[k] = bus.m_ack_o; r_err[k] = bus.m_err_o; r_rty[k] = bus.m_rty_o;
          r_dat[k] = bus.m_dat_o; r_cresp[k] = bus.s_cyc_o; r_lat[k] = lat;
          if (bitof(bus.m_ack_o, k)) r_nack[k]++;
        end
      end
      if (!done) begin
        n_tests++; n_fail++;
        $display("FAIL xfer_timeout: master %0d got no response, expected one within 100 cycles", k);
      end
      @(posedge clk); #1;
    end
    bus.m_cyc_i[k] = 1'b0;
    bus.m_stb_i[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [7:0] seq_bits();
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < gseq.size() && i < 8; i++) s[i] = gseq[i][0];
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1;
    bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0; bus.m_we_i = '0;
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_cti_i = '0; bus.m_bte_i = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_scyc", {bus.s_cyc_o, bus.s_stb_o}, 0);
    chk("rst_resp", {bus.m_ack_o, bus.m_err_o, bus.m_rty_o}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single read from master 0
    smode = 1;
    xfer(0, 1, 1'b0, 32'h0000_1000, 32'h0);
    chk("rd_scyc_c0", r_c0[0], 1'b0);
    chk("rd_scyc_c1", r_c1[0], 1'b1);
    chk("rd_latency", r_lat[0], 3);
    chk("rd_ack_vec", r_ack[0], 2'b01);
    chk("rd_data", r_dat[0], 32'hDEADBEEF);
    @(negedge clk);
    chk("rd_grant_idle", grant, 2'b00);
    @(posedge clk); #1;

    // both masters, 4 single writes each, requested together
    do_reset();
    gseq.delete(); gaps.delete();
    fork
      for (int i = 0; i < 4; i++) xfer(0, 1, 1'b1, 32'h100 + 32'(i*4), 32'hA000 + 32'(i));
      for (int i = 0; i < 4; i++) xfer(1, 1, 1'b1, 32'h200 + 32'(i*4), 32'hB000 + 32'(i));
    join
    chk("alt_count", gseq.size(), 8);
    chk("alt_seq", seq_bits(), 8'hAA);
    n1 = 0;
    foreach (gaps[i]) if (gaps[i] == 1) n1++;
    chk("alt_gaps", n1, 7);

    // master 1 burst must not be split by master 0
    do_reset();
    gseq.delete(); gaps.delete();
    fork
      xfer(1, 4, 1'b1, 32'h3000, 32'hC000);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        xfer(0, 1, 1'b0, 32'h4000, 32'h0);
      end
    join
    chk("burst_acks", r_nack[1], 4);
    chk("burst_order", {gseq.size() == 2, seq_bits()}, 9'h101);

    // err then rty to master 1
    do_reset();
    smode = 2;
    xfer(1, 1, 1'b0, 32'h5000, 32'h0);
    chk("err_vec", r_err[1], 2'b10);
    chk("err_noack", r_ack[1], 2'b00);
    smode = 3;
    xfer(1, 1, 1'b0, 32'h5004, 32'h0);
    chk("rty_vec", r_rty[1], 2'b10);

`ifdef WB_ARB_TIMEOUT_EN
    // hung slave: watchdog aborts master 0, master 1 follows
    do_reset();
    gseq.delete(); gaps.delete();
    smode = 0;
    fork
      begin
        xfer(0, 1, 1'b0, 32'h6000, 32'h0);
        smode = 1;
      end
      begin
        @(posedge clk); #1;
        xfer(1, 1, 1'b0, 32'h7000, 32'h0);
      end
    join
    chk("to_latency", r_lat[0], 9);
    chk("to_err_vec", r_err[0], 2'b01);
    chk("to_scyc", r_cresp[0], 1'b0);
    chk("to_next_ack", r_ack[1], 2'b10);
    chk("to_order", seq_bits(), 8'h02);
`endif

    // reset during a master 1 transfer
    do_reset();
    smode = 0;
    bus.m_cyc_i[1] = 1'b1; bus.m_stb_i[1] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_busy_grant", grant, 2'b10);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.m_cyc_i[0] = 1'b1; bus.m_stb_i[0] = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", grant, 2'b00);
    chk("post_rst_scyc", bus.s_cyc_o, 1'b0);
    chk("post_rst_resp", {bus.m_ack_o, bus.m_err_o, bus.m_rty_o}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_winner", grant, 2'b01);
    @(posedge clk); #1;
    bus.m_cyc_i = '0; bus.m_stb_i = '0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
